// File: rtl/mpmc11_app_responder.sv
// Block-RAM stand-in for the DDR app interface: commands and write data queue separately,
// pair in FIFO order, and reads come back in order RD_LATENCY+1 edges after acceptance.
module mpmc11_app_responder #(
    parameter int DATA_WIDTH     = 128,
    parameter int ADDR_WIDTH     = 29,
    parameter int ADDR_LSB       = 3,
    parameter int MEM_DEPTH_LOG2 = 10,
    parameter int RD_LATENCY     = 8,
    parameter int CMDQ_DEPTH     = 4,
    parameter int WDQ_DEPTH      = 4,
    parameter int CALIB_CYCLES   = 64,
    parameter int BUSY_PERIOD    = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    calib_complete,
    input  logic                    app_en,
    input  logic [2:0]              app_cmd,
    input  logic [ADDR_WIDTH-1:0]   app_addr,
    output logic                    app_rdy,
    input  logic                    app_wdf_wren,
    input  logic [DATA_WIDTH-1:0]   app_wdf_data,
    input  logic [DATA_WIDTH/8-1:0] app_wdf_mask,
    input  logic                    app_wdf_end,
    output logic                    app_wdf_rdy,
    output logic [DATA_WIDTH-1:0]   app_rd_data,
    output logic                    app_rd_data_valid,
    output logic                    app_rd_data_end
);
    localparam int NB  = DATA_WIDTH / 8;
    localparam int CPW = (CMDQ_DEPTH > 1) ? $clog2(CMDQ_DEPTH) : 1;
    localparam int WPW = (WDQ_DEPTH > 1) ? $clog2(WDQ_DEPTH) : 1;
    localparam int CW  = $clog2(CALIB_CYCLES + 1);
    localparam int BP  = (BUSY_PERIOD > 0) ? BUSY_PERIOD : 1;
    localparam int BW  = (BP > 1) ? $clog2(BP) : 1;

    typedef enum logic {ST_CALIB = 1'b0, ST_RUN = 1'b1} state_e;

    state_e                    state_q;
    logic [CW-1:0]             cal_cnt_q;
    logic                      calib_q, app_rdy_q, wdf_rdy_q;
    logic [BW-1:0]             busy_q, busy_d;
    logic                      throttle_d;

    logic                      cq_rd_q  [CMDQ_DEPTH];
    logic [MEM_DEPTH_LOG2-1:0] cq_idx_q [CMDQ_DEPTH];
    logic [CPW-1:0]            cq_wp_q, cq_rp_q;
    logic [CPW:0]              cq_cnt_q, cq_cnt_d;
    logic [DATA_WIDTH-1:0]     wq_data_q [WDQ_DEPTH];
    logic [NB-1:0]             wq_mask_q [WDQ_DEPTH];
    logic [WPW-1:0]            wq_wp_q, wq_rp_q;
    logic [WPW:0]              wq_cnt_q, wq_cnt_d;

    logic                      cq_push_s, cq_pop_s, wq_push_s, head_vld_s, do_wr_s, do_rd_s;
    logic                      cq_room_s, wq_room_s;

    logic [DATA_WIDTH-1:0]     mem_q [2**MEM_DEPTH_LOG2];
    logic [DATA_WIDTH-1:0]     dat_q [RD_LATENCY];
    logic [RD_LATENCY-1:0]     vld_q;
    logic                      rd_valid_q;
    logic [DATA_WIDTH-1:0]     rd_data_q;
    logic                      unused_bits;

    assign unused_bits = ^{app_wdf_end, app_addr};

    // Handshakes, head-of-queue decisions and next occupancies.
    always_comb begin
        cq_push_s  = app_en && app_rdy_q && (app_cmd == 3'd0 || app_cmd == 3'd1);
        wq_push_s  = app_wdf_wren && wdf_rdy_q;
        head_vld_s = (cq_cnt_q != '0);
        do_wr_s    = head_vld_s && !cq_rd_q[cq_rp_q] && (wq_cnt_q != '0);
        do_rd_s    = head_vld_s && cq_rd_q[cq_rp_q];
        cq_pop_s   = do_wr_s || do_rd_s;
        cq_cnt_d   = cq_cnt_q + (CPW+1)'(cq_push_s) - (CPW+1)'(cq_pop_s);
        wq_cnt_d   = wq_cnt_q + (WPW+1)'(wq_push_s) - (WPW+1)'(do_wr_s);
        cq_room_s  = (cq_cnt_d != (CPW+1)'(CMDQ_DEPTH));
        wq_room_s  = (wq_cnt_d != (WPW+1)'(WDQ_DEPTH));
        if (busy_q == BW'(BP - 1)) begin
            busy_d = '0;
        end else begin
            busy_d = busy_q + BW'(1);
        end
        throttle_d = (BUSY_PERIOD > 0) && (busy_d == BW'(BP - 1));
    end

    // Calibration/run FSM; owns the registered status and ready outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_CALIB;
            cal_cnt_q <= '0;
            calib_q   <= 1'b0;
            app_rdy_q <= 1'b0;
            wdf_rdy_q <= 1'b0;
        end else begin
            case (state_q)
                ST_CALIB: begin
                    if (cal_cnt_q == CW'(CALIB_CYCLES - 1)) begin
                        state_q   <= ST_RUN;
                        calib_q   <= 1'b1;
                        app_rdy_q <= cq_room_s && !throttle_d;
                        wdf_rdy_q <= wq_room_s;
                    end else begin
                        cal_cnt_q <= cal_cnt_q + CW'(1);
                        calib_q   <= 1'b0;
                        app_rdy_q <= 1'b0;
                        wdf_rdy_q <= 1'b0;
                    end
                end
                ST_RUN: begin
                    calib_q   <= 1'b1;
                    app_rdy_q <= cq_room_s && !throttle_d;
                    wdf_rdy_q <= wq_room_s;
                end
                default: begin
                    state_q   <= ST_CALIB;
                    cal_cnt_q <= '0;
                    calib_q   <= 1'b0;
                    app_rdy_q <= 1'b0;
                    wdf_rdy_q <= 1'b0;
                end
            endcase
        end
    end

    // Free-running throttle phase counter and queue pointers/occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q   <= '0;
            cq_wp_q  <= '0;
            cq_rp_q  <= '0;
            cq_cnt_q <= '0;
            wq_wp_q  <= '0;
            wq_rp_q  <= '0;
            wq_cnt_q <= '0;
        end else begin
            busy_q   <= busy_d;
            cq_cnt_q <= cq_cnt_d;
            wq_cnt_q <= wq_cnt_d;
            if (cq_push_s) cq_wp_q <= cq_wp_q + CPW'(1);
            if (cq_pop_s)  cq_rp_q <= cq_rp_q + CPW'(1);
            if (wq_push_s) wq_wp_q <= wq_wp_q + WPW'(1);
            if (do_wr_s)   wq_rp_q <= wq_rp_q + WPW'(1);
        end
    end

    // Queue storage needs no reset: only entries below the occupancy are ever read.
    always_ff @(posedge clk) begin
        if (cq_push_s) begin
            cq_rd_q[cq_wp_q]  <= app_cmd[0];
            cq_idx_q[cq_wp_q] <= app_addr[ADDR_LSB +: MEM_DEPTH_LOG2];
        end
        if (wq_push_s) begin
            wq_data_q[wq_wp_q] <= app_wdf_data;
            wq_mask_q[wq_wp_q] <= app_wdf_mask;
        end
    end

    // Block RAM with byte-lane write enables and a registered read feeding the data pipe.
    always_ff @(posedge clk) begin
        if (do_wr_s) begin
            for (int b = 0; b < NB; b++) begin
                if (!wq_mask_q[wq_rp_q][b]) begin
                    mem_q[cq_idx_q[cq_rp_q]][b*8 +: 8] <= wq_data_q[wq_rp_q][b*8 +: 8];
                end
            end
        end
        if (do_rd_s) dat_q[0] <= mem_q[cq_idx_q[cq_rp_q]];
        for (int k = 1; k < RD_LATENCY; k++) dat_q[k] <= dat_q[k-1];
    end

    // Valid pipe is reset so a reset kills every read in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            vld_q      <= {vld_q[RD_LATENCY-2:0], do_rd_s};
            rd_valid_q <= vld_q[RD_LATENCY-1];
            if (vld_q[RD_LATENCY-1]) rd_data_q <= dat_q[RD_LATENCY-1];
        end
    end

    assign calib_complete    = calib_q;
    assign app_rdy           = app_rdy_q;
    assign app_wdf_rdy       = wdf_rdy_q;
    assign app_rd_data       = rd_data_q;
    assign app_rd_data_valid = rd_valid_q;
    assign app_rd_data_end   = rd_valid_q;
endmodule

// File: tb/tb_mpmc11_app_responder.sv
// Randomized bench for mpmc11_app_responder: a transaction-level memory model predicts
// every read, plus directed checks of calibration, latency, masking, stalls and reset.
module tb_mpmc11_app_responder;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         calib_complete, app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data_end;
    logic         app_en = 1'b0;
    logic [2:0]   app_cmd = 3'd0;
    logic [28:0]  app_addr = '0;
    logic         app_wdf_wren = 1'b0;
    logic [127:0] app_wdf_data = '0;
    logic [15:0]  app_wdf_mask = '0;
    logic         app_wdf_end = 1'b1;
    logic [127:0] app_rd_data;

    mpmc11_app_responder #(.BUSY_PERIOD(3)) dut (
        .clk(clk), .rst(rst), .calib_complete(calib_complete),
        .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr), .app_rdy(app_rdy),
        .app_wdf_wren(app_wdf_wren), .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
        .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
        .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
        .app_rd_data_end(app_rd_data_end)
    );

    always #5 clk = ~clk;

    typedef struct { logic [2:0] cmd; logic [28:0] addr; } cmd_t;
    typedef struct { logic [127:0] data; logic [15:0] mask; } wd_t;
    typedef struct { bit wr; int idx; } mc_t;

    int n_chk = 0, n_err = 0;
    int cyc = 0, base_cyc = 0;
    int en_pct = 100, wr_pct = 100, wd_hold_until = 0;
    int acc_c_cyc = -1, acc_w_cyc = -1, n_acc_c = 0;
    int n_vld = 0, last_vld_cyc = -1;
    logic [127:0] last_rd = '0;

    cmd_t snd_c[$];
    wd_t  snd_w[$];
    mc_t  mdl_c[$];
    wd_t  mdl_w[$];
    logic [127:0] exp_q[$];
    logic [127:0] mdl_mem [1024];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int rel();
        return cyc - base_cyc;
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: commands execute in acceptance order, writes paired FIFO with data.
    function automatic void model_cmd(input cmd_t c);
        mc_t m;
        m.wr  = (c.cmd == 3'd0);
        m.idx = (int'(c.addr) >> 3) % 1024;
        if (c.cmd == 3'd0 || c.cmd == 3'd1) mdl_c.push_back(m);
    endfunction

    function automatic void drain();
        while (mdl_c.size() != 0) begin
            if (mdl_c[0].wr) begin
                if (mdl_w.size() == 0) break;
                for (int b = 0; b < 16; b++)
                    if (!mdl_w[0].mask[b]) mdl_mem[mdl_c[0].idx][b*8 +: 8] = mdl_w[0].data[b*8 +: 8];
                void'(mdl_w.pop_front());
            end else begin
                exp_q.push_back(mdl_mem[mdl_c[0].idx]);
            end
            void'(mdl_c.pop_front());
        end
    endfunction

    always @(posedge clk) begin
        #2;
        if (app_rd_data_valid) begin
            n_vld++;
            last_vld_cyc = rel();
            last_rd = app_rd_data;
            chk("rd_end", app_rd_data_end, 1'b1);
            if (exp_q.size() == 0) chk("unexpected_valid", 1'b1, 1'b0);
            else chk("rd_data", app_rd_data, exp_q.pop_front());
        end
    end

    task automatic step();
        logic ac, aw;
        cmd_t c;
        wd_t  w;
        app_en = (snd_c.size() != 0) && ($urandom_range(99) < en_pct);
        if (snd_c.size() != 0) begin
            app_cmd  = snd_c[0].cmd;
            app_addr = snd_c[0].addr;
        end
        app_wdf_wren = (snd_w.size() != 0) && (rel() >= wd_hold_until) && ($urandom_range(99) < wr_pct);
        if (snd_w.size() != 0) begin
            app_wdf_data = snd_w[0].data;
            app_wdf_mask = snd_w[0].mask;
        end
        ac = app_en && app_rdy;
        aw = app_wdf_wren && app_wdf_rdy;
        @(posedge clk);
        #1;
        if (ac) begin
            c = snd_c.pop_front();
            acc_c_cyc = rel();
            n_acc_c++;
            model_cmd(c);
        end
        if (aw) begin
            w = snd_w.pop_front();
            acc_w_cyc = rel();
            mdl_w.push_back(w);
        end
        drain();
        if (rel() % 3 == 2) chk("throttle", app_rdy, 1'b0);
    endtask

    task automatic send_cmd(input logic [2:0] cmd, input logic [28:0] addr);
        cmd_t c;
        c.cmd = cmd; c.addr = addr;
        snd_c.push_back(c);
    endtask

    task automatic send_wd(input logic [127:0] data, input logic [15:0] mask);
        wd_t w;
        w.data = data; w.mask = mask;
        snd_w.push_back(w);
    endtask

    task automatic run_idle(input string tag, input int limit);
        int n = 0;
        while ((snd_c.size() + snd_w.size() + mdl_c.size() + exp_q.size()) != 0 && n < limit) begin
            step();
            n++;
        end
        chk({tag, "_done"}, n < limit, 1'b1);
        repeat (12) step();
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] d1;
        int v0, rd_acc, n, n_rd;
        logic [28:0] a;
        d1 = 128'h0123456789ABCDEF0123456789ABCDEF;

        // Reset values.
        @(posedge clk); #1;
        chk("rst_calib", calib_complete, 1'b0);
        chk("rst_rdy", app_rdy, 1'b0);
        chk("rst_wdf_rdy", app_wdf_rdy, 1'b0);
        chk("rst_vld", app_rd_data_valid, 1'b0);
        chk("rst_end", app_rd_data_end, 1'b0);
        chk("rst_data", app_rd_data, 128'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        base_cyc = cyc;

        // Calibration with command and data held, then write/read latency.
        send_cmd(3'd0, 29'h40); send_wd(d1, 16'h0); send_cmd(3'd1, 29'h40);
        for (int i = 1; i <= 64; i++) begin
            step();
            if (i < 64) begin
                chk("calib_lo", calib_complete, 1'b0);
                chk("rdy_lo_calib", app_rdy, 1'b0);
                chk("wdf_rdy_lo_calib", app_wdf_rdy, 1'b0);
            end
        end
        chk("calib_hi", calib_complete, 1'b1);
        chk("rdy_hi_calib", app_rdy, 1'b1);
        chk("wdf_rdy_hi_calib", app_wdf_rdy, 1'b1);
        chk("no_acc_calib", n_acc_c, 0);
        step();
        chk("wr_acc_cyc", acc_c_cyc, 65);
        chk("wd_acc_cyc", acc_w_cyc, 65);
        n = 0;
        while (snd_c.size() != 0 && n < 10) begin step(); n++; end
        rd_acc = acc_c_cyc;
        run_idle("wr_rd", 40);
        chk("rd_latency", last_vld_cyc - rd_acc, 9);
        chk("wr_rd_data", last_rd, d1);
        chk("wr_rd_pulses", n_vld, 1);

        // Byte mask and address aliasing.
        send_cmd(3'd0, 29'h8);    send_wd({128{1'b1}}, 16'h0);
        send_cmd(3'd0, 29'h8);    send_wd(128'h0, 16'h00FF);
        send_cmd(3'd1, 29'h2008);
        run_idle("mask", 60);
        chk("mask_alias", last_rd, {64'h0, 64'hFFFF_FFFF_FFFF_FFFF});

        // Write data 20 cycles late: reads stall behind it and the queue fills.
        v0 = n_vld;
        send_cmd(3'd0, 29'h100); send_wd(rnd128(), 16'h0);
        send_cmd(3'd1, 29'h100); send_cmd(3'd1, 29'h40);
        send_cmd(3'd1, 29'h8);   send_cmd(3'd1, 29'h100);
        wd_hold_until = rel() + 20;
        while (rel() < wd_hold_until - 1) step();
        chk("cmdq_full_rdy", app_rdy, 1'b0);
        chk("cmdq_full_left", snd_c.size(), 1);
        chk("stall_no_pulse", n_vld - v0, 0);
        run_idle("late", 80);
        chk("late_pulses", n_vld - v0, 4);

        // Write data ahead of commands fills the data queue.
        v0 = n_vld;
        for (int k = 0; k < 5; k++) send_wd(rnd128(), 16'(k * 16'h1111));
        repeat (8) step();
        chk("wdq_full_rdy", app_wdf_rdy, 1'b0);
        chk("wdq_full_left", snd_w.size(), 1);
        for (int k = 0; k < 5; k++) send_cmd(3'd0, 29'(32'h200 + k * 8));
        for (int k = 0; k < 5; k++) send_cmd(3'd1, 29'(32'h200 + k * 8));
        run_idle("early", 100);
        chk("early_pulses", n_vld - v0, 5);

        // Six reads with app_en held against the throttle.
        v0 = n_vld;
        send_cmd(3'd1, 29'h40);  send_cmd(3'd1, 29'h8);   send_cmd(3'd1, 29'h100);
        send_cmd(3'd1, 29'h200); send_cmd(3'd1, 29'h208); send_cmd(3'd1, 29'h2008);
        run_idle("bp", 60);
        chk("bp_pulses", n_vld - v0, 6);

        // Randomized traffic over eight aliased locations.
        v0 = n_vld;
        n_rd = 0;
        en_pct = 70;
        wr_pct = 60;
        for (int k = 0; k < 8; k++) begin
            a = 29'(((32'h300 + k) << 3) | $urandom_range(7) | ($urandom_range(3) << 13));
            send_cmd(3'd0, a); send_wd(rnd128(), 16'h0);
        end
        for (int i = 0; i < 60; i++) begin
            n = $urandom_range(99);
            a = 29'(((32'h300 + $urandom_range(7)) << 3) | $urandom_range(7) | ($urandom_range(3) << 13));
            if (n < 40) begin
                send_cmd(3'd0, a); send_wd(rnd128(), 16'($urandom));
            end else if (n < 85) begin
                send_cmd(3'd1, a); n_rd++;
            end else begin
                send_cmd(3'($urandom_range(7, 2)), a);
            end
        end
        run_idle("rand", 3000);
        chk("rand_pulses", n_vld - v0, n_rd);
        en_pct = 100;
        wr_pct = 100;

        // Reset three cycles after a read is accepted.
        v0 = n_vld;
        send_cmd(3'd1, 29'h40);
        n = 0;
        while (snd_c.size() != 0 && n < 20) begin step(); n++; end
        chk("rst_rd_acc", snd_c.size(), 0);
        repeat (3) step();
        rst = 1'b1;
        #1;
        chk("mid_rst_calib", calib_complete, 1'b0);
        chk("mid_rst_rdy", app_rdy, 1'b0);
        chk("mid_rst_wdf_rdy", app_wdf_rdy, 1'b0);
        chk("mid_rst_vld", app_rd_data_valid, 1'b0);
        chk("mid_rst_data", app_rd_data, 128'h0);
        snd_c.delete(); snd_w.delete(); mdl_c.delete(); mdl_w.delete(); exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        base_cyc = cyc;
        for (int i = 1; i <= 64; i++) begin
            step();
            if (i == 63) chk("recal_lo", calib_complete, 1'b0);
        end
        chk("recal_hi", calib_complete, 1'b1);
        repeat (20) step();
        chk("rst_no_pulse", n_vld - v0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
